im_fetch_ctrl: RTL
==================

# im_fetch_ctrl

Sequencer and arbiter for the 4 KB synchronous-read instruction memory in the multicycle CPU. Two requesters share the single memory read port: the CPU fetch stage (instruction fetch into IR) and a debug/loader read port. The block grants one request at a time, drives the word address, absorbs the memory's one-cycle registered-read latency and returns the word with a one-cycle acknowledge. Misaligned or out-of-range addresses are rejected without touching the memory.

## Interface
- `STARVE_MAX`, default 4: consecutive CPU grants allowed while a debug request waits; the next grant then goes to debug.
- `clk` input 1: single clock, all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `if_req` input 1: CPU fetch request; held with `if_pc` stable until `if_ack`.
- `if_pc` input 32: CPU byte address.
- `if_ack` output 1: one-cycle pulse; fetch complete.
- `if_instr` output 32: fetched word; updated only on an `if_ack` cycle, holds its value otherwise.
- `if_err` output 1: qualifies `if_ack`; high means misaligned or out of range.
- `dbg_req` input 1: debug read request; same hold rule as `if_req`.
- `dbg_addr` input 32: debug byte address.
- `dbg_ack` output 1: one-cycle pulse.
- `dbg_data` output 32: read word; updated only on a `dbg_ack` cycle.
- `dbg_err` output 1: qualifies `dbg_ack`.
- `im_addr` output 10: registered word address `[11:2]` to the instruction memory.
- `im_dout` input 32: memory data, valid on the cycle after the edge that samples `im_addr`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ, CAPT, RESP. State and all outputs are registered.
- **IDLE, no request:** stay in IDLE.
- **IDLE, request granted, address legal:**
  - Latch the owner.
  - Set `im_addr <= addr[11:2]`.
  - Go to READ.
- **Address legal:** `addr[1:0]==0` and `addr[31:12]==0`.
- **IDLE, request granted, address illegal:**
  - Go directly to RESP.
  - Owner's ack=1, err=1, data=0.
  - `im_addr` is unchanged.
- **READ:** go to CAPT unconditionally. The memory registers `im_dout` on this edge.
- **CAPT:**
  - Owner's data register `<= im_dout`, ack=1, err=0.
  - Go to RESP.
- **RESP:**
  - The ack and err asserted on entry are visible for exactly this cycle.
  - On exit they clear to 0; data registers hold.
  - Go to IDLE.
- **Arbitration, only one request present:** grant it.
- **Arbitration, both present:** grant CPU unless `starve_cnt==STARVE_MAX`, in which case grant debug.
- **`starve_cnt` (3 bits, saturating at STARVE_MAX):**
  - +1 on each CPU grant while `dbg_req` is high.
  - Cleared on a debug grant.
  - Cleared on any cycle with `dbg_req` low.
- **Reset (`rst_n` low, any state):**
  - State = IDLE, `starve_cnt` = 0.
  - `im_addr`, `if_instr`, `dbg_data` = 0.
  - All ack/err = 0, `busy` = 0.
  - An in-flight access is abandoned; no ack is produced for it.
- **Requester rules:**
  - A requester may drop req in its ack cycle.
  - A req still high in the ack cycle is treated as a new request, sampled in IDLE on the following edge.
  - A requester that drops req before its ack is out of spec; the access still completes and acks.

## Timing
- Legal access:
  - Edge N: IDLE samples req.
  - Edge N+1: READ → CAPT; memory output updates.
  - Edge N+2: data captured, ack rises.
  - Edge N+3: ack falls, back to IDLE.
  - Ack is high during cycle N+2..N+3.
- Illegal access: ack/err high during cycle N..N+1 (RESP), then IDLE.
- Back-to-back legal accesses: one grant per 4 cycles. Back-to-back illegal: one per 2 cycles.
- `busy` is high from the edge after grant through RESP.
- `if_ack` and `dbg_ack` are never high in the same cycle.

## Test plan
- **Single fetch:** mem[2]=0x20080005; after reset `if_req=1`, `if_pc=0x00000008` at edge 0 → `im_addr=0x002` after edge 0; `if_ack=1`, `if_instr=0x20080005`, `if_err=0` after edge 2; `if_ack=0` after edge 3.
- **Illegal addresses:**
  - `if_pc=0x00000006` → `if_ack=1`, `if_err=1` after edge 0; `im_addr` unchanged; `if_instr=0`.
  - `dbg_addr=0x00001000` → `dbg_ack=1`, `dbg_err=1` after edge 0.
- **Starvation guard:** `STARVE_MAX=4`; `if_req` and `dbg_req` held high continuously → grant order CPU, CPU, CPU, CPU, DBG, CPU…; acks spaced 4 cycles apart; `if_ack` and `dbg_ack` never coincide.
- **Debug-only read:** mem[0x3FF]=0xDEADBEEF, `dbg_addr=0x00000FFC` → `dbg_data=0xDEADBEEF` after edge 2; `if_instr` unchanged.
- **Reset mid-read:** `rst_n` low during CAPT → outputs zero immediately, no ack; after release a new `if_req` completes normally in 3 cycles.
- **Held request:** `if_req` held through ack at `pc=0x4` → second grant sampled at edge 4, second ack after edge 6.

Source files
------------

// File: rtl/im_fetch_if.sv
// Request/response and memory-port bundle between the requesters, the
// instruction memory and the fetch controller.
interface im_fetch_if;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_ack;
  logic [31:0] if_instr;
  logic        if_err;

  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic        dbg_err;

  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic        busy;

  modport slave (
    input  if_req, if_pc, dbg_req, dbg_addr, im_dout,
    output if_ack, if_instr, if_err, dbg_ack, dbg_data, dbg_err, im_addr, busy
  );

  modport master (
    output if_req, if_pc, dbg_req, dbg_addr, im_dout,
    input  if_ack, if_instr, if_err, dbg_ack, dbg_data, dbg_err, im_addr, busy
  );
endinterface

// File: rtl/im_fetch_ctrl.sv
// Arbiter/sequencer sharing the 4 KB synchronous-read instruction memory
// between CPU fetch and a debug read port; one access in flight at a time.
module im_fetch_ctrl #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic       clk,
  input logic       rst_n,
  im_fetch_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [1:0]  state;
  logic        owner_dbg;
  logic [2:0]  starve_cnt;

  logic        grant_if;
  logic        grant_dbg;
  logic [31:0] req_addr;
  logic        addr_ok;

  // Grants are only issued from IDLE; debug wins when it is alone or when the
  // CPU has taken STARVE_MAX grants in a row while debug was waiting.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant_if  = 1'b0;
    grant_dbg = 1'b0;
    if (state == S_IDLE) begin
      if (bus.dbg_req && (!bus.if_req || starve_cnt == STARVE_LIM))
        grant_dbg = 1'b1;
      else if (bus.if_req)
        grant_if = 1'b1;
    end
    req_addr = grant_dbg ? bus.dbg_addr : bus.if_pc;
    addr_ok  = (req_addr[1:0] == 2'b00) && (req_addr[31:12] == 20'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      owner_dbg    <= 1'b0;
      starve_cnt   <= 3'd0;
      bus.im_addr  <= 10'd0;
      bus.if_ack   <= 1'b0;
      bus.if_err   <= 1'b0;
      bus.if_instr <= 32'd0;
      bus.dbg_ack  <= 1'b0;
      bus.dbg_err  <= 1'b0;
      bus.dbg_data <= 32'd0;
      bus.busy     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      if (!bus.dbg_req || grant_dbg)
        starve_cnt <= 3'd0;
      else if (grant_if && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 3'd1;

      case (state)
        S_IDLE: begin
          if (grant_if || grant_dbg) begin
            owner_dbg <= grant_dbg;
            bus.busy  <= 1'b1;
            if (addr_ok) begin
              bus.im_addr <= req_addr[11:2];
              state       <= S_READ;
            end else begin
              // Rejected without touching the memory: answer straight away.
              state <= S_RESP;
              if (grant_dbg) begin
                bus.dbg_ack  <= 1'b1;
                bus.dbg_err  <= 1'b1;
                bus.dbg_data <= 32'd0;
              end else begin
                bus.if_ack   <= 1'b1;
                bus.if_err   <= 1'b1;
                bus.if_instr <= 32'd0;
              end
            end
          end
        end
        S_READ: state <= S_CAPT;
        S_CAPT: begin
          state <= S_RESP;
          if (owner_dbg) begin
            bus.dbg_data <= bus.im_dout;
            bus.dbg_ack  <= 1'b1;
            bus.dbg_err  <= 1'b0;
          end else begin
            bus.if_instr <= bus.im_dout;
            bus.if_ack   <= 1'b1;
            bus.if_err   <= 1'b0;
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          bus.busy    <= 1'b0;
          bus.if_ack  <= 1'b0;
          bus.if_err  <= 1'b0;
          bus.dbg_ack <= 1'b0;
          bus.dbg_err <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
